adder_operand_gen: RTL and testbench
====================================

ADDER_OPERAND_GEN -- requirements
Module: adder_operand_gen

Interface
REQ-001 Parameter ADDER_WIDTH, default 22, operand width; legal range 1..32.
REQ-002 Parameter NUM_VECTORS, default 256, operand pairs emitted per run; legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  level; begins a run when sampled high in IDLE.
REQ-006 seed  input  32  LFSR seed, sampled on the accepted start cycle.
REQ-007 out_ready  input  1  downstream adder stage accepts the current pair.
REQ-008 out_valid  output  1  a/b hold a valid pair.
REQ-009 a  output  ADDER_WIDTH  operand A.
REQ-010 b  output  ADDER_WIDTH  operand B.
REQ-011 count  output  16  pairs transferred in the current or last run.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 checksum  output  ADDER_WIDTH+1  running sum of a+b; present only per REQ-033.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-016 IDLE with start=1 SHALL go to LOAD, load lfsr from seed, substitute 32'h00000001 if seed==0, and clear count.
REQ-017 LOAD SHALL go to RUN unconditionally after one cycle; out_valid rises on entry to RUN.
REQ-018 a SHALL equal lfsr[ADDER_WIDTH-1:0]; b SHALL equal lfsr[31:32-ADDER_WIDTH].
REQ-019 LFSR step: next = {1'b0, lfsr[31:1]} XOR (lfsr[0] ? 32'h80200003 : 0).
REQ-020 Transfer = out_valid AND out_ready; each transfer SHALL advance the LFSR by one step and increment count by 1.
REQ-021 While out_valid=1 and out_ready=0, a, b, out_valid and lfsr SHALL hold stable.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.
REQ-023 Back-to-back transfers SHALL sustain one pair per cycle with out_ready held high.
REQ-024 A transfer with count==NUM_VECTORS-1 SHALL go to DONE and deassert out_valid on the next cycle.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE; count SHALL hold its final value until the next start.
REQ-026 start SHALL be ignored outside IDLE; start held high through DONE SHALL begin a new run from IDLE.
REQ-027 NUM_VECTORS=1: exactly one pair emitted, then DONE.
REQ-028 count SHALL never wrap within a run, as guaranteed by the NUM_VECTORS range.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, out_valid=0, busy=0, done=0, count=0, a=0, b=0, lfsr=32'h00000001, and checksum=0 when present.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; the next run starts only from a fresh start.
REQ-031 rst_n has priority over start and out_ready in the same cycle.

Configuration
REQ-032 Macro OPGEN_CHECKSUM_EN selects the checksum feature.
REQ-033 Defined: checksum port exists, clears on the accepted start cycle, and adds (a+b) mod 2^(ADDER_WIDTH+1) on each transfer, wrapping modulo 2^(ADDER_WIDTH+1).
REQ-034 Undefined: no checksum port or register; all other behaviour identical.

Verification
REQ-035 Reset, then start=1 with seed=0x00000001 and out_ready=1 -> first pair a=0x000001, b=0x000000; second pair a=0x200003, b=0x200800.
REQ-036 seed=0 -> identical pair sequence to seed=0x00000001.
REQ-037 out_ready low for 5 cycles while out_valid=1 -> a, b and count unchanged for all 5 cycles; no pair skipped or duplicated.
REQ-038 NUM_VECTORS=4, out_ready=1 -> exactly 4 transfers, count=4, done high for exactly 1 cycle, busy low afterwards.
REQ-039 rst_n low for 1 cycle after 2 transfers -> next cycle out_valid=0, count=0, no done pulse.
REQ-040 With OPGEN_CHECKSUM_EN, seed=1, two transfers -> checksum=0x400804.

Source files
------------

// File: rtl/adder_operand_gen.sv
// ============================================================================
//  Module   : adder_operand_gen
//  Purpose  : Generates pseudo-random operand pairs (a, b) for a downstream
//             adder stage from a 32-bit Galois LFSR. A run emits NUM_VECTORS
//             pairs over a valid/ready handshake, then pulses done.
//  Ports    : clk        - sole clock, rising edge
//             rst_n      - synchronous active-low reset
//             start      - level; begins a run when sampled high in IDLE
//             seed       - LFSR seed, captured on the accepted start cycle
//             out_ready  - downstream accepts the current pair
//             out_valid  - a/b hold a valid pair
//             a, b       - operands (low / high slices of the LFSR)
//             count      - pairs transferred in the current or last run
//             busy       - high in LOAD and RUN
//             done       - one-cycle pulse at end of run
//             checksum   - running sum of a+b (only with OPGEN_CHECKSUM_EN)
//  Config   : define OPGEN_CHECKSUM_EN to add the checksum port and register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_operand_gen #(
    parameter int ADDER_WIDTH = 22,
    parameter int NUM_VECTORS = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            seed,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b,
    output logic [15:0]            count,
    output logic                   busy,
    output logic                   done
`ifdef OPGEN_CHECKSUM_EN
    ,
    output logic [ADDER_WIDTH:0]   checksum
`endif
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_load = 2'd1;
    localparam logic [1:0]  c_st_run  = 2'd2;
    localparam logic [1:0]  c_st_done = 2'd3;

    localparam logic [31:0] c_taps     = 32'h80200003;
    localparam logic [15:0] c_last_cnt = 16'(NUM_VECTORS - 1);

    logic [1:0]             r_state;
    logic [31:0]            r_lfsr;
    logic                   r_out_valid;
    logic [ADDER_WIDTH-1:0] r_a;
    logic [ADDER_WIDTH-1:0] r_b;
    logic [15:0]            r_count;
    logic                   r_busy;
    logic                   r_done;

    logic [31:0]            w_lfsr_step;
    logic [31:0]            w_seed_eff;
    logic                   w_xfer;

    // A zero seed would lock the LFSR at zero forever.
    assign w_seed_eff  = (seed == 32'h0) ? 32'h00000001 : seed;
    assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_taps : 32'h0);
    assign w_xfer      = r_out_valid & out_ready;

    // a/b are registered copies of the LFSR slices, reloaded together with
    // the LFSR so they always reflect its current value without a comb path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_lfsr      <= 32'h00000001;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_count     <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_load;
                        r_lfsr  <= w_seed_eff;
                        r_a     <= w_seed_eff[ADDER_WIDTH-1:0];
                        r_b     <= w_seed_eff[31:32-ADDER_WIDTH];
                        r_count <= 16'd0;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_load: begin
                    r_state     <= c_st_run;
                    r_out_valid <= 1'b1;
                end
                c_st_run: begin
                    if (w_xfer) begin
                        r_lfsr  <= w_lfsr_step;
                        r_a     <= w_lfsr_step[ADDER_WIDTH-1:0];
                        r_b     <= w_lfsr_step[31:32-ADDER_WIDTH];
                        r_count <= r_count + 16'd1;
                        if (r_count == c_last_cnt) begin
                            r_state     <= c_st_done;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPGEN_CHECKSUM_EN
    logic [ADDER_WIDTH:0] r_checksum;
    logic [ADDER_WIDTH:0] w_pair_sum;

    // Sum carried one bit wider than the operands; accumulation wraps.
    assign w_pair_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if ((r_state == c_st_idle) && start) begin
            r_checksum <= '0;
        end else if ((r_state == c_st_run) && w_xfer) begin
            r_checksum <= r_checksum + w_pair_sum;
        end
    end

    assign checksum = r_checksum;
`endif

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign count     = r_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_adder_operand_gen.sv
// ============================================================================
//  Module   : tb_adder_operand_gen
//  Purpose  : Self-checking bench for adder_operand_gen (4-vector runs).
//             Expected operand pairs come from a reference LFSR model and are
//             queued when a run is started, then popped on each transfer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_operand_gen;

    localparam int W  = 22;
    localparam int NV = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   seed;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [15:0]   count;
    logic          busy;
    logic          done;
`ifdef OPGEN_CHECKSUM_EN
    logic [W:0]    checksum;
`endif

    adder_operand_gen #(
        .ADDER_WIDTH (W),
        .NUM_VECTORS (NV)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a         (a),
        .b         (b),
        .count     (count),
        .busy      (busy),
        .done      (done)
`ifdef OPGEN_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] pa;
        logic [W-1:0] pb;
    } pair_t;

    pair_t q_exp[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    xfers      = 0;
    int    done_seen  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] m);
        return {1'b0, m[31:1]} ^ (m[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic push_pairs(input logic [31:0] s, input int n);
        logic [31:0] m;
        pair_t       p;
        m = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < n; i++) begin
            p.pa = m[W-1:0];
            p.pb = m[31:32-W];
            q_exp.push_back(p);
            m = model_step(m);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; a pair seen with
    // valid&ready here is the one the upcoming edge transfers.
    task automatic cycle();
        pair_t p;
        if (rst_n && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("sb_underflow", 64'(q_exp.size()), 64'd1);
            end else begin
                p = q_exp.pop_front();
                chk("pair_a", 64'(a), 64'(p.pa));
                chk("pair_b", 64'(b), 64'(p.pb));
            end
            xfers++;
        end
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    task automatic run_xfers(input int n, input int budget);
        int base;
        int k;
        base = xfers;
        k    = 0;
        while ((xfers - base) < n && k < budget) begin
            cycle();
            k++;
        end
        chk("xfer_budget", 64'(xfers - base), 64'(n));
    endtask

    initial begin
        logic [W-1:0] hold_a;
        logic [W-1:0] hold_b;
        logic [15:0]  hold_cnt;
        logic [31:0]  rseed;

        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = 32'h0;
        out_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_a",     64'(a),         64'd0);
        chk("rst_b",     64'(b),         64'd0);
`ifdef OPGEN_CHECKSUM_EN
        chk("rst_checksum", 64'(checksum), 64'd0);
`endif

        // Run 1: seed 1, out_ready held high
        seed      = 32'h00000001;
        push_pairs(seed, NV);
        done_seen = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        chk("load_busy",  64'(busy),      64'd1);
        chk("load_valid", 64'(out_valid), 64'd0);
        cycle();
        chk("run_valid", 64'(out_valid), 64'd1);
        chk("first_a",   64'(a),         64'h000001);
        chk("first_b",   64'(b),         64'h000000);
        cycle();
        chk("second_a",  64'(a),         64'h200003);
        chk("second_b",  64'(b),         64'h200800);
        cycle();
`ifdef OPGEN_CHECKSUM_EN
        chk("checksum_2", 64'(checksum), 64'h400804);
`endif
        run_xfers(2, 10);
        chk("end_valid", 64'(out_valid), 64'd0);
        repeat (3) cycle();
        chk("run1_done_pulses", 64'(done_seen),    64'd1);
        chk("run1_count",       64'(count),        64'(NV));
        chk("run1_busy",        64'(busy),         64'd0);
        chk("run1_sb_empty",    64'(q_exp.size()), 64'd0);

        // Run 2: seed 0 behaves like seed 1; 5-cycle stall after one transfer
        seed      = 32'h0;
        push_pairs(seed, NV);
        done_seen = 0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        hold_a   = a;
        hold_b   = b;
        hold_cnt = count;
        chk("stall_entry_count", 64'(count), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_a",     64'(a),         64'(hold_a));
            chk("stall_b",     64'(b),         64'(hold_b));
            chk("stall_count", 64'(count),     64'(hold_cnt));
            chk("stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        run_xfers(3, 10);
        repeat (3) cycle();
        chk("run2_done_pulses", 64'(done_seen),    64'd1);
        chk("run2_count",       64'(count),        64'(NV));
        chk("run2_sb_empty",    64'(q_exp.size()), 64'd0);

        // Run 3: random seed, start held through DONE restarts a run
        rseed = $urandom;
        seed  = rseed;
        push_pairs(rseed, NV);
        push_pairs(rseed, NV);
        done_seen = 0;
        start     = 1'b1;
        run_xfers(NV, 12);
        chk("run3_done", 64'(done), 64'd1);
        cycle();
        cycle();
        chk("restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        run_xfers(2, 10);

        // Mid-run reset after two transfers
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_count", 64'(count),     64'd0);
        chk("abort_busy",  64'(busy),      64'd0);
        chk("abort_done",  64'(done),      64'd0);
        chk("abort_a",     64'(a),         64'd0);
        q_exp.delete();
        done_seen = 0;
        repeat (6) cycle();
        chk("abort_no_done",    64'(done_seen), 64'd0);
        chk("abort_no_restart", 64'(busy),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
